seq_det_moore_param: RTL and testbench
======================================

// Module: seq_det_moore_param
// PURPOSE
// - Parametrised Moore sequence detector; generalises the fixed 5-bit 11011 detectors to any LEN-bit pattern.
// - Overlapping or non-overlapping mode is selected by parameter. A sample-valid qualifier is added.
// - Sits on a 1-bit serial stream and flags each completed pattern for downstream control logic.
// PARAMETERS
// - LEN          5          pattern length in bits, 2..16
// - PATTERN      5'b11011   pattern, LEN bits; PATTERN[LEN-1] is the first bit received (MSB first)
// - OVERLAP      1          1 = overlapping detection, 0 = non-overlapping
// - MATCH_CNT_W  8          match counter width; used only with SEQ_DET_MATCH_CNT_EN
// PORTS
// - clk        in   1            rising-edge clock
// - rst        in   1            synchronous reset, active-high
// - in_valid   in   1            signal is sampled only when high
// - signal     in   1            serial input bit
// - out        out  1            Moore match flag
// - cnt_clr    in   1            [SEQ_DET_MATCH_CNT_EN only] synchronous counter clear
// - match_cnt  out  MATCH_CNT_W  [SEQ_DET_MATCH_CNT_EN only] number of matches
// BEHAVIOUR
// - State register S in 0..LEN holds the count of pattern bits currently matched (prefix length).
//   Width is clog2(LEN+1).
// - Reset: when rst=1 at a clk edge, S<=0, out<=0 (and match_cnt<=0). rst has priority over all other inputs.
// - in_valid=0: S, out and match_cnt hold.
// - in_valid=1, S<LEN: S <= delta(S, signal), where delta is the longest prefix of PATTERN
//   that is a suffix of (matched prefix + signal). This is a KMP transition.
//   Compute the delta table at elaboration (function/generate), not with run-time search.
// - In state S, the expected next bit is PATTERN[LEN-1-S].
// - in_valid=1, S==LEN, OVERLAP=1: S <= delta(F, signal), where F is the longest proper
//   border of PATTERN. For 11011, F=2.
// - in_valid=1, S==LEN, OVERLAP=0: S <= delta(0, signal). No pattern bit is reused.
// - out is a register equal to (S==LEN). It is high for the cycle after the edge that samples the final bit.
// - out stays high while in_valid=0 in state LEN.
// - Back-to-back matches are possible only with OVERLAP=1 and a pattern whose border is LEN-1.
//   Example: 1111 gives out high on consecutive valid cycles.
// - Reset mid-sequence discards partial progress; the first valid bit after reset is treated as bit 0.
// - out and match_cnt have no combinational path from inputs.
// CONFIGURATION
// - SEQ_DET_MATCH_CNT_EN defined: adds cnt_clr and match_cnt.
//   - match_cnt increments by 1 on each edge where next S==LEN and in_valid=1.
//   - match_cnt saturates at all-ones.
//   - If cnt_clr and an increment occur on the same edge, the result is 1 (clear then count).
//   - rst clears match_cnt to 0.
// - SEQ_DET_MATCH_CNT_EN undefined: the cnt_clr and match_cnt ports and the counter logic are absent.
//   Detection behaviour is identical in both builds.
// TESTING
// - Defaults, in_valid=1, rst released, stream 1,1,0,1,1,0,1,1 -> out high after bits 5 and 8 only.
// - OVERLAP=0, same stream -> out high after bit 5 only; S=2 after bit 8.
// - Stream 1,1,0,1,1 with in_valid low for 3 cycles between bits 3 and 4 -> exactly one match after bit 5;
//   out does not change during the gap.
// - rst pulsed after bits 1,1,0,1, then 1,1,0,1,1 -> out low during and after reset; one match after the 2nd bit 5.
// - LEN=4, PATTERN=4'b1111, OVERLAP=1, six 1s -> out high after bits 4, 5 and 6.
// - With SEQ_DET_MATCH_CNT_EN, MATCH_CNT_W=2, five matches -> match_cnt 1,2,3,3,3.
//   Then cnt_clr together with a match -> match_cnt=1.

Source files
------------

// File: rtl/seq_det_moore_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_moore_param
// Description : Parametrised Moore sequence detector for a 1-bit serial
//               stream. Tracks the length of the matched pattern prefix
//               with a KMP transition table built at elaboration time.
//               Overlapping or non-overlapping detection is set by OVERLAP.
//               Optional match counter: define SEQ_DET_MATCH_CNT_EN to
//               add the cnt_clr input and the match_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_moore_param #(
    parameter int               LEN         = 5,
    parameter logic [LEN-1:0]   PATTERN     = 5'b11011,
    parameter bit               OVERLAP     = 1'b1,
    parameter int               MATCH_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   signal,
`ifdef SEQ_DET_MATCH_CNT_EN
    input  logic                   cnt_clr,
    output logic [MATCH_CNT_W-1:0] match_cnt,
`endif
    output logic                   out
);

    // ------------------------------------------------------------------
    // Elaboration-time helpers
    // ------------------------------------------------------------------

    // Longest proper border of PATTERN (prefix that is also a suffix).
    function automatic int border_f();
        int res;
        bit ok;
        res = 0;
        for (int k = 1; k < LEN; k++) begin
            ok = 1'b1;
            for (int j = 0; j < LEN; j++) begin
                if (j < k) begin
                    if (PATTERN[LEN-1-j] != PATTERN[k-1-j]) begin
                        ok = 1'b0;
                    end
                end
            end
            if (ok) begin
                res = k;
            end
        end
        return res;
    endfunction

    // KMP transition: longest PATTERN prefix that is a suffix of
    // (first s pattern bits followed by bit b). Valid for s < LEN.
    function automatic int delta_f(input int s, input int b);
        int res;
        int idx;
        bit ok;
        bit ch;
        res = 0;
        for (int k = 1; k <= LEN; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int j = 0; j < LEN; j++) begin
                    if (j < k) begin
                        idx = s + 1 - k + j;
                        if (idx == s) begin
                            ch = b[0];
                        end else begin
                            ch = PATTERN[LEN-1-idx];
                        end
                        if (PATTERN[LEN-1-j] != ch) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_sw       = $clog2(LEN + 1);
    localparam int c_nstates  = 1 << c_sw;
    localparam int c_border   = border_f();
    // After a full match, resume from the border (overlap) or from scratch.
    localparam int c_restart  = OVERLAP ? c_border : 0;

    localparam logic [c_sw-1:0] c_s_idle  = '0;
    localparam logic [c_sw-1:0] c_s_match = c_sw'(LEN);

    // ------------------------------------------------------------------
    // Parameter sanity checks
    // ------------------------------------------------------------------
    if (LEN < 2 || LEN > 16) begin : g_bad_len
        $error("seq_det_moore_param: LEN must be in 2..16");
    end
    if (MATCH_CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_det_moore_param: MATCH_CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Transition table, one entry per encodable state and input bit.
    // Encodings above LEN are unreachable; they fall back to idle.
    // ------------------------------------------------------------------
    logic [c_sw-1:0] w_delta0 [c_nstates];
    logic [c_sw-1:0] w_delta1 [c_nstates];

    for (genvar gs = 0; gs < c_nstates; gs++) begin : g_delta
        if (gs < LEN) begin : g_partial
            localparam logic [c_sw-1:0] c_d0 = c_sw'(delta_f(gs, 0));
            localparam logic [c_sw-1:0] c_d1 = c_sw'(delta_f(gs, 1));
            assign w_delta0[gs] = c_d0;
            assign w_delta1[gs] = c_d1;
        end else if (gs == LEN) begin : g_full
            localparam logic [c_sw-1:0] c_d0 = c_sw'(delta_f(c_restart, 0));
            localparam logic [c_sw-1:0] c_d1 = c_sw'(delta_f(c_restart, 1));
            assign w_delta0[gs] = c_d0;
            assign w_delta1[gs] = c_d1;
        end else begin : g_unused
            assign w_delta0[gs] = c_s_idle;
            assign w_delta1[gs] = c_s_idle;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [c_sw-1:0] state_q;
    logic [c_sw-1:0] state_d;
    logic            out_q;
    logic            out_d;

    // State and registered match flag; reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_s_idle;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Next state: advance through the KMP table only on valid samples.
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            state_d = signal ? w_delta1[state_q] : w_delta0[state_q];
        end
    end

    // Moore output: flag is registered so it mirrors the state being entered.
    always_comb begin
        out_d = (state_d == c_s_match);
    end

    assign out = out_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    // ------------------------------------------------------------------
    // Saturating match counter
    // ------------------------------------------------------------------
    logic [MATCH_CNT_W-1:0] cnt_q;
    logic [MATCH_CNT_W-1:0] cnt_d;
    logic                   w_inc;

    assign w_inc = in_valid && (state_d == c_s_match);

    // Clear first, then count, so a clear coinciding with a match yields 1.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end
        if (w_inc && (cnt_d != {MATCH_CNT_W{1'b1}})) begin
            cnt_d = cnt_d + MATCH_CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_moore_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_moore_param
// Description : Directed self-checking bench for seq_det_moore_param.
//               Three instances: default 11011 overlapping, 11011
//               non-overlapping, and 1111 overlapping (LEN=4). Counter
//               checks are compiled in when SEQ_DET_MATCH_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_moore_param;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic in_valid = 1'b0;
    logic signal   = 1'b0;
    logic out_a;
    logic out_b;
    logic out_c;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic       cnt_clr = 1'b0;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [1:0] cnt_c;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_det_moore_param dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .signal    (signal),
`ifdef SEQ_DET_MATCH_CNT_EN
        .cnt_clr   (cnt_clr),
        .match_cnt (cnt_a),
`endif
        .out       (out_a)
    );

    seq_det_moore_param #(
        .OVERLAP (1'b0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .signal    (signal),
`ifdef SEQ_DET_MATCH_CNT_EN
        .cnt_clr   (cnt_clr),
        .match_cnt (cnt_b),
`endif
        .out       (out_b)
    );

    seq_det_moore_param #(
        .LEN         (4),
        .PATTERN     (4'b1111),
        .OVERLAP     (1'b1),
        .MATCH_CNT_W (2)
    ) dut_c (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .signal    (signal),
`ifdef SEQ_DET_MATCH_CNT_EN
        .cnt_clr   (cnt_clr),
        .match_cnt (cnt_c),
`endif
        .out       (out_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of input, then settle just after the rising edge.
    task automatic send(input logic v, input logic b);
        in_valid = v;
        signal   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bit [7:0] stream;
        bit [7:0] exp_a;
        bit [7:0] exp_b;
        bit [4:0] s5;
        bit [4:0] e5;
        bit [5:0] e6;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);
        check("rst_out_c", 32'(out_c), 32'd0);
`ifdef SEQ_DET_MATCH_CNT_EN
        check("rst_cnt_c", 32'(cnt_c), 32'd0);
`endif
        rst = 1'b0;

        // Stream 11011011: overlap matches after bits 5 and 8, non-overlap after 5 only
        stream = 8'b11011011;
        exp_a  = 8'b00001001;
        exp_b  = 8'b00001000;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, stream[7-i]);
            check($sformatf("ovl_bit%0d", i + 1), 32'(out_a), 32'(exp_a[7-i]));
            check($sformatf("novl_bit%0d", i + 1), 32'(out_b), 32'(exp_b[7-i]));
        end
        check("novl_state_after8", 32'(dut_b.state_q), 32'd2);

        // Valid gap between bits 3 and 4; out must not move during the gap
        do_reset();
        s5 = 5'b11011;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, s5[4-i]);
            check($sformatf("gap_pre_bit%0d", i + 1), 32'(out_a), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'(i % 2 == 0));
            check($sformatf("gap_idle%0d", i), 32'(out_a), 32'd0);
        end
        send(1'b1, s5[1]);
        check("gap_bit4", 32'(out_a), 32'd0);
        send(1'b1, s5[0]);
        check("gap_bit5", 32'(out_a), 32'd1);
        // Flag holds in the match state while no valid samples arrive
        send(1'b0, 1'b0);
        check("hold_idle1", 32'(out_a), 32'd1);
        send(1'b0, 1'b1);
        check("hold_idle2", 32'(out_a), 32'd1);

        // Reset mid-sequence after 1,1,0,1; reset edge sees a completing bit
        do_reset();
        send(1'b1, 1'b1);
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        rst = 1'b1;
        send(1'b1, 1'b1);
        check("rst_prio_out", 32'(out_a), 32'd0);
        rst = 1'b0;
        e5 = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, s5[4-i]);
            check($sformatf("post_rst_bit%0d", i + 1), 32'(out_a), 32'(e5[4-i]));
        end

        // LEN=4 1111 overlapping: six 1s give out after bits 4, 5, 6
        do_reset();
`ifdef SEQ_DET_MATCH_CNT_EN
        check("cnt_after_rst", 32'(cnt_c), 32'd0);
`endif
        e6 = 6'b000111;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 1'b1);
            check($sformatf("ones_bit%0d", i + 1), 32'(out_c), 32'(e6[5-i]));
            check($sformatf("ones_a_bit%0d", i + 1), 32'(out_a), 32'd0);
`ifdef SEQ_DET_MATCH_CNT_EN
            check($sformatf("cnt_bit%0d", i + 1), 32'(cnt_c), 32'((i < 3) ? 0 : i - 2));
`endif
        end
        // Matches 4 and 5: counter saturates at 3
        for (int i = 0; i < 2; i++) begin
            send(1'b1, 1'b1);
            check($sformatf("ones_more%0d", i), 32'(out_c), 32'd1);
`ifdef SEQ_DET_MATCH_CNT_EN
            check($sformatf("cnt_sat%0d", i), 32'(cnt_c), 32'd3);
`endif
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        // Clear coinciding with a match gives 1; clear alone gives 0
        cnt_clr = 1'b1;
        send(1'b1, 1'b1);
        check("cnt_clr_with_match", 32'(cnt_c), 32'd1);
        send(1'b0, 1'b0);
        check("cnt_clr_only", 32'(cnt_c), 32'd0);
        check("clr_out_hold", 32'(out_c), 32'd1);
        cnt_clr = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
